// File: rtl/verichip_alu_q.sv
// verichip_alu_q: register-mapped ALU with a host command queue, maroon/gold
// state machine, export-disable lockout and two W1C interrupts.
// Optional feature macro: VCHIP_ALU_MUL_EN adds command 8 (signed MUL).
module verichip_alu_q #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 7
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                export_disable,
    output logic                interrupt_1,
    output logic                interrupt_2,
    input  logic                maroon,
    input  logic                gold,
    input  logic                chip_select,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                rw_,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out
);
    localparam int NB    = DATA_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MSB   = DATA_W - 1;

`ifdef VCHIP_ALU_MUL_EN
    localparam logic [3:0] LAST_CMD  = 4'd8;
    localparam logic [3:0] VER_MINOR = 4'h1;
`else
    localparam logic [3:0] LAST_CMD  = 4'd7;
    localparam logic [3:0] VER_MINOR = 4'h0;
`endif

    localparam logic [ADDR_W-1:0] A_VER = ADDR_W'('h00);
    localparam logic [ADDR_W-1:0] A_STA = ADDR_W'('h04);
    localparam logic [ADDR_W-1:0] A_CMD = ADDR_W'('h08);
    localparam logic [ADDR_W-1:0] A_CON = ADDR_W'('h0C);
    localparam logic [ADDR_W-1:0] A_LFT = ADDR_W'('h10);
    localparam logic [ADDR_W-1:0] A_RGT = ADDR_W'('h14);
    localparam logic [ADDR_W-1:0] A_ALU = ADDR_W'('h18);
    localparam logic [ADDR_W-1:0] A_FST = ADDR_W'('h1C);

    typedef enum logic [3:0] {
        ST_RESET = 4'h0,
        ST_NORM  = 4'h1,
        ST_ERR   = 4'h2,
        ST_EXP   = 4'h8,
        ST_LOST  = 4'hF
    } state_t;

    typedef enum logic [3:0] {
        C_NONE = 4'd0, C_ADD = 4'd1, C_SUB = 4'd2, C_MVL = 4'd3,
        C_MVR  = 4'd4, C_SWA = 4'd5, C_SHL = 4'd6, C_SHR = 4'd7,
        C_MUL  = 4'd8
    } cmd_t;

    state_t              r_state, w_next_state;
    logic [3:0]          r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [3:0]          r_drop_cnt;
    logic                r_int1, r_int2, r_int1_en, r_int2_en, r_export_dis;
    logic [DATA_W-1:0]   r_lft, r_rgt, r_alu;

    logic                w_wr, w_host_ok, w_push_req, w_push_ok, w_push, w_drop, w_pop;
    logic                w_empty, w_full, w_exp_viol, w_bad, w_ovf, w_alu_we;
    logic                w_mvl, w_mvr, w_swa, w_exp_entry, w_set1, w_set2;
    logic                w_wr_lft, w_wr_rgt, w_wr_con, w_wr_sta;
    logic [3:0]          w_head, w_entry;
    logic [DATA_W-1:0]   w_sum, w_dif, w_res, w_lft_nxt, w_rgt_nxt, w_rd;

    assign w_wr       = chip_select && !rw_;
    assign w_host_ok  = (r_state == ST_RESET) || (r_state == ST_NORM);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_head     = r_fifo[r_rd_ptr];
    assign w_pop      = (r_state == ST_NORM) && !w_empty;
    assign w_push_req = w_wr && (address == A_CMD) && data_in[MSB] && byte_en[NB-1];
    assign w_push_ok  = (r_state == ST_RESET) || (r_state == ST_NORM) || (r_state == ST_ERR);
    assign w_push     = w_push_req && w_push_ok && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_push_ok && w_full && !w_pop;
    assign w_entry    = byte_en[0] ? data_in[3:0] : C_NONE;
    assign w_wr_lft   = w_wr && (address == A_LFT) && w_host_ok;
    assign w_wr_rgt   = w_wr && (address == A_RGT) && w_host_ok;
    assign w_wr_con   = w_wr && (address == A_CON) && w_host_ok && byte_en[1];
    assign w_wr_sta   = w_wr && (address == A_STA) && byte_en[1];
    assign w_sum      = r_lft + r_rgt;
    assign w_dif      = r_lft - r_rgt;
    assign w_exp_viol = w_pop && r_export_dis && (w_head > 4'd2);

`ifdef VCHIP_ALU_MUL_EN
    logic signed [2*DATA_W-1:0] w_prod;
    logic                       w_prod_fits;
    assign w_prod      = $signed(r_lft) * $signed(r_rgt);
    assign w_prod_fits = (&w_prod[2*DATA_W-1:MSB]) || !(|w_prod[2*DATA_W-1:MSB]);
`endif

    // Decode and execute the popped head command.
    always_comb begin
        w_res    = r_alu;
        w_alu_we = 1'b0;
        w_ovf    = 1'b0;
        w_bad    = 1'b0;
        w_mvl    = 1'b0;
        w_mvr    = 1'b0;
        w_swa    = 1'b0;
        if (w_pop && !w_exp_viol) begin
            if (w_head > LAST_CMD) begin
                w_bad = 1'b1;
            end else begin
                case (w_head)
                    C_ADD: begin
                        w_res = w_sum;
                        w_ovf = (r_lft[MSB] == r_rgt[MSB]) && (w_sum[MSB] != r_lft[MSB]);
                    end
                    C_SUB: begin
                        w_res = w_dif;
                        w_ovf = (r_lft[MSB] != r_rgt[MSB]) && (w_dif[MSB] != r_lft[MSB]);
                    end
                    C_MVL: w_mvl = 1'b1;
                    C_MVR: w_mvr = 1'b1;
                    C_SWA: w_swa = 1'b1;
                    C_SHL: w_res = (r_rgt >= DATA_W'(DATA_W)) ? '0 : (r_lft << r_rgt);
                    C_SHR: w_res = (r_rgt >= DATA_W'(DATA_W)) ? '0 : (r_lft >> r_rgt);
`ifdef VCHIP_ALU_MUL_EN
                    C_MUL: begin
                        w_res = w_prod[DATA_W-1:0];
                        w_ovf = !w_prod_fits;
                    end
`endif
                    default: ;
                endcase
                w_alu_we = !w_ovf && ((w_head == C_ADD) || (w_head == C_SUB) ||
                           (w_head == C_SHL) || (w_head == C_SHR) || (w_head == C_MUL));
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= ST_RESET;
        else        r_state <= w_next_state;
    end

    // Next-state logic for the maroon/gold machine.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RESET: if (!maroon && gold) w_next_state = ST_NORM;
            ST_NORM: begin
                if (w_exp_viol)          w_next_state = ST_EXP;
                else if (w_bad || w_ovf) w_next_state = ST_ERR;
            end
            ST_ERR:   if (maroon && !gold) w_next_state = ST_NORM;
            ST_EXP:   w_next_state = ST_EXP;
            ST_LOST:  w_next_state = ST_LOST;
            default:  w_next_state = ST_LOST;
        endcase
    end

    assign w_exp_entry = (r_state == ST_NORM) && (w_next_state == ST_EXP);
    assign w_set1      = (r_state == ST_NORM) && (w_next_state == ST_ERR) && r_int1_en;
    assign w_set2      = w_exp_entry && r_int2_en;

    // Export-disable pin is sampled on every edge, reset or not.
    always_ff @(posedge clk) r_export_dis <= export_disable;

    // Command queue storage, pointers, occupancy and drop counter.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop && (r_drop_cnt != 4'hF)) r_drop_cnt <= r_drop_cnt + 4'd1;
            if (w_exp_entry) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_fifo[r_wr_ptr] <= w_entry;
                    r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Operand next values: ALU moves/swap first, then host byte writes override.
    always_comb begin
        w_lft_nxt = r_lft;
        w_rgt_nxt = r_rgt;
        if (w_mvl) w_lft_nxt = r_alu;
        if (w_mvr) w_rgt_nxt = r_alu;
        if (w_swa) begin
            w_lft_nxt = r_rgt;
            w_rgt_nxt = r_lft;
        end
        for (int unsigned b = 0; b < NB; b++) begin
            if (w_wr_lft && byte_en[b]) w_lft_nxt[8*b +: 8] = data_in[8*b +: 8];
            if (w_wr_rgt && byte_en[b]) w_rgt_nxt[8*b +: 8] = data_in[8*b +: 8];
        end
    end

    // Operand, result, enable and interrupt registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_lft     <= '0;
            r_rgt     <= '0;
            r_alu     <= '0;
            r_int1_en <= 1'b0;
            r_int2_en <= 1'b0;
            r_int1    <= 1'b0;
            r_int2    <= 1'b0;
        end else begin
            if (w_exp_entry) begin
                r_lft     <= '0;
                r_rgt     <= '0;
                r_alu     <= '0;
                r_int1_en <= 1'b0;
                r_int2_en <= 1'b0;
            end else begin
                r_lft <= w_lft_nxt;
                r_rgt <= w_rgt_nxt;
                if (w_alu_we) r_alu <= w_res;
                if (w_wr_con) begin
                    r_int1_en <= data_in[8];
                    r_int2_en <= data_in[9];
                end
            end
            if (w_set1)                      r_int1 <= 1'b1;
            else if (w_wr_sta && data_in[8]) r_int1 <= 1'b0;
            if (w_set2)                      r_int2 <= 1'b1;
            else if (w_wr_sta && data_in[9]) r_int2 <= 1'b0;
        end
    end

    assign interrupt_1 = r_int1;
    assign interrupt_2 = r_int2;

    // Combinational register read mux with export lockout masking.
    always_comb begin
        w_rd = '0;
        case (address)
            A_VER: w_rd[15:0] = {r_export_dis, 3'b000, 4'h3, 4'h2, VER_MINOR};
            A_STA: begin
                w_rd[9]   = r_int2;
                w_rd[8]   = r_int1;
                w_rd[3:0] = r_state;
            end
            A_CMD: begin
                w_rd[MSB] = !w_empty;
                w_rd[3:0] = w_empty ? 4'h0 : w_head;
            end
            A_CON: begin
                w_rd[9] = r_int2_en;
                w_rd[8] = r_int1_en;
            end
            A_LFT: w_rd = r_lft;
            A_RGT: w_rd = r_rgt;
            A_ALU: w_rd = r_alu;
            A_FST: begin
                w_rd[15:12] = r_drop_cnt;
                w_rd[9]     = w_full;
                w_rd[8]     = w_empty;
                w_rd[7:0]   = 8'(r_count);
            end
            default: w_rd = '0;
        endcase
        data_out = '0;
        if (chip_select) begin
            if (((r_state == ST_EXP) || (w_next_state == ST_EXP)) && (address != A_STA))
                data_out = '0;
            else
                data_out = w_rd;
        end
    end
endmodule

// File: tb/tb_verichip_alu_q.sv
// Directed, table-driven bench for verichip_alu_q (DATA_W=16, FIFO_DEPTH=4).
module tb_verichip_alu_q;
    localparam logic [6:0] A_VER = 7'h00, A_STA = 7'h04, A_CMD = 7'h08, A_CON = 7'h0C;
    localparam logic [6:0] A_LFT = 7'h10, A_RGT = 7'h14, A_ALU = 7'h18, A_FST = 7'h1C;
`ifdef VCHIP_ALU_MUL_EN
    localparam logic [15:0] MINOR = 16'h0001, MUL_ALU = 16'hFFFA, MUL_STA = 16'h0001;
`else
    localparam logic [15:0] MINOR = 16'h0000, MUL_ALU = 16'h0800, MUL_STA = 16'h0102;
`endif

    logic        clk = 1'b0, rst_b = 1'b0, export_disable = 1'b0;
    logic        maroon = 1'b0, gold = 1'b0, chip_select = 1'b0, rw_ = 1'b1;
    logic [6:0]  address = '0;
    logic [1:0]  byte_en = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        interrupt_1, interrupt_2;

    verichip_alu_q #(.DATA_W(16), .FIFO_DEPTH(4), .ADDR_W(7)) dut (
        .clk(clk), .rst_b(rst_b), .export_disable(export_disable),
        .interrupt_1(interrupt_1), .interrupt_2(interrupt_2),
        .maroon(maroon), .gold(gold), .chip_select(chip_select),
        .address(address), .byte_en(byte_en), .rw_(rw_),
        .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          cs;
        bit          rw;
        logic [6:0]  addr;
        logic [15:0] wd;
        logic [1:0]  be;
        bit          m;
        bit          g;
        bit          ck;
        logic [15:0] exp;
        bit          ic;
        logic [1:0]  iexp;
    } vec_t;

    vec_t tv[$];
    bit   m_s = 1'b0, g_s = 1'b0;
    int   n_pass = 0, n_tot = 0;

    function automatic vec_t mk(bit cs, bit rw, logic [6:0] a, logic [15:0] d, logic [1:0] be,
                                bit ck, logic [15:0] e, bit ic, logic [1:0] ie);
        vec_t t;
        t.cs = cs; t.rw = rw; t.addr = a; t.wd = d; t.be = be;
        t.m = m_s; t.g = g_s; t.ck = ck; t.exp = e; t.ic = ic; t.iexp = ie;
        return t;
    endfunction

    function automatic vec_t wr_v(logic [6:0] a, logic [15:0] d, logic [1:0] be);
        return mk(1'b1, 1'b0, a, d, be, 1'b0, 16'h0, 1'b0, 2'b00);
    endfunction
    function automatic vec_t rd_v(logic [6:0] a, logic [15:0] e);
        return mk(1'b1, 1'b1, a, 16'h0, 2'b00, 1'b1, e, 1'b0, 2'b00);
    endfunction
    function automatic vec_t rdi_v(logic [6:0] a, logic [15:0] e, logic [1:0] ie);
        return mk(1'b1, 1'b1, a, 16'h0, 2'b00, 1'b1, e, 1'b1, ie);
    endfunction
    function automatic vec_t idle_v();
        return mk(1'b0, 1'b1, 7'h00, 16'h0, 2'b00, 1'b0, 16'h0, 1'b0, 2'b00);
    endfunction

    task automatic check16(input string nm, input int id, input logic [15:0] got, input logic [15:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s#%0d got=%h exp=%h", nm, id, got, exp);
    endtask

    // One bus cycle: drive after the falling edge, sample 1ns later.
    task automatic cyc(input vec_t t, input string tag, input int id);
        @(negedge clk);
        chip_select = t.cs; rw_ = t.rw; address = t.addr; data_in = t.wd;
        byte_en = t.be; maroon = t.m; gold = t.g;
        #1;
        if (t.ck) check16(tag, id, data_out, t.exp);
        if (t.ic) check16({tag, "_irq"}, id, {14'd0, interrupt_2, interrupt_1}, {14'd0, t.iexp});
    endtask

    task automatic do_reset(input bit xd);
        export_disable = xd;
        chip_select = 1'b0; rw_ = 1'b1; maroon = 1'b0; gold = 1'b0;
        m_s = 1'b0; g_s = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check16("rst_irq", 0, {14'd0, interrupt_2, interrupt_1}, 16'h0);
        check16("rst_dout", 0, data_out, 16'h0);
        rst_b = 1'b1;
    endtask

    initial begin
        // Main table: basic ops, operand moves, shifts, overflow/ERR, bad cmds.
        tv.push_back(rdi_v(A_STA, 16'h0000, 2'b00));
        tv.push_back(rd_v(A_VER, 16'h0320 | MINOR));
        tv.push_back(rd_v(A_FST, 16'h0100));
        tv.push_back(wr_v(A_LFT, 16'h0005, 2'b11));
        tv.push_back(wr_v(A_RGT, 16'h0003, 2'b11));
        tv.push_back(rd_v(A_LFT, 16'h0005));
        tv.push_back(rd_v(A_RGT, 16'h0003));
        tv.push_back(wr_v(A_CMD, 16'h8001, 2'b11));
        tv.push_back(wr_v(A_CMD, 16'h8002, 2'b11));
        tv.push_back(rd_v(A_FST, 16'h0002));
        tv.push_back(rd_v(A_CMD, 16'h8001));
        g_s = 1'b1;
        tv.push_back(rd_v(A_STA, 16'h0000));
        tv.push_back(rd_v(A_STA, 16'h0001));
        tv.push_back(rd_v(A_ALU, 16'h0008));
        tv.push_back(rd_v(A_ALU, 16'h0002));
        tv.push_back(rd_v(A_FST, 16'h0100));
        tv.push_back(mk(1'b0, 1'b1, A_ALU, 16'h0, 2'b00, 1'b1, 16'h0000, 1'b0, 2'b00));
        tv.push_back(wr_v(A_LFT, 16'h1200, 2'b11));
        tv.push_back(wr_v(A_CMD, 16'h8001, 2'b11));
        tv.push_back(wr_v(A_CMD, 16'h8003, 2'b11));
        tv.push_back(wr_v(A_LFT, 16'h00AA, 2'b01));
        tv.push_back(wr_v(A_CMD, 16'h8005, 2'b11));
        tv.push_back(rd_v(A_LFT, 16'h12AA));
        tv.push_back(rd_v(A_LFT, 16'h0003));
        tv.push_back(rd_v(A_RGT, 16'h12AA));
        tv.push_back(wr_v(A_CMD, 16'h8004, 2'b11));
        tv.push_back(idle_v());
        tv.push_back(rd_v(A_RGT, 16'h1203));
        tv.push_back(wr_v(A_CMD, 16'h8006, 2'b11));
        tv.push_back(wr_v(A_RGT, 16'h0004, 2'b11));
        tv.push_back(rd_v(A_ALU, 16'h0000));
        tv.push_back(wr_v(A_CMD, 16'h8006, 2'b11));
        tv.push_back(idle_v());
        tv.push_back(rd_v(A_ALU, 16'h0030));
        tv.push_back(wr_v(A_LFT, 16'h8000, 2'b11));
        tv.push_back(wr_v(A_CMD, 16'h8007, 2'b11));
        tv.push_back(idle_v());
        tv.push_back(rd_v(A_ALU, 16'h0800));
        tv.push_back(wr_v(A_CON, 16'h0100, 2'b10));
        tv.push_back(wr_v(A_LFT, 16'h7FFF, 2'b11));
        tv.push_back(wr_v(A_RGT, 16'h0001, 2'b11));
        tv.push_back(wr_v(A_CMD, 16'h8001, 2'b11));
        tv.push_back(wr_v(A_CMD, 16'h8001, 2'b11));
        tv.push_back(rdi_v(A_STA, 16'h0102, 2'b01));
        tv.push_back(rd_v(A_ALU, 16'h0800));
        tv.push_back(rd_v(A_FST, 16'h0001));
        tv.push_back(wr_v(A_LFT, 16'h1111, 2'b11));
        tv.push_back(rd_v(A_LFT, 16'h7FFF));
        m_s = 1'b1; g_s = 1'b0;
        tv.push_back(rd_v(A_STA, 16'h0102));
        m_s = 1'b0; g_s = 1'b1;
        tv.push_back(rd_v(A_STA, 16'h0101));
        tv.push_back(rd_v(A_STA, 16'h0102));
        m_s = 1'b1; g_s = 1'b0;
        tv.push_back(rd_v(A_FST, 16'h0100));
        m_s = 1'b0; g_s = 1'b1;
        tv.push_back(wr_v(A_STA, 16'h0100, 2'b10));
        tv.push_back(rdi_v(A_STA, 16'h0001, 2'b00));
        tv.push_back(wr_v(A_LFT, 16'h0100, 2'b11));
        tv.push_back(wr_v(A_RGT, 16'h0100, 2'b11));
        tv.push_back(wr_v(A_CMD, 16'h8008, 2'b11));
        tv.push_back(idle_v());
        tv.push_back(rdi_v(A_STA, 16'h0102, 2'b01));
        tv.push_back(rd_v(A_ALU, 16'h0800));
        m_s = 1'b1; g_s = 1'b0;
        tv.push_back(idle_v());
        m_s = 1'b0; g_s = 1'b1;
        tv.push_back(wr_v(A_CMD, 16'h800F, 2'b11));
        tv.push_back(idle_v());
        tv.push_back(rd_v(A_STA, 16'h0102));
        m_s = 1'b1; g_s = 1'b0;
        tv.push_back(idle_v());
        m_s = 1'b0; g_s = 1'b1;
        tv.push_back(wr_v(A_STA, 16'h0100, 2'b10));
        tv.push_back(wr_v(A_LFT, 16'h0003, 2'b11));
        tv.push_back(wr_v(A_RGT, 16'hFFFE, 2'b11));
        tv.push_back(wr_v(A_CMD, 16'h8008, 2'b11));
        tv.push_back(idle_v());
        tv.push_back(rd_v(A_ALU, MUL_ALU));
        tv.push_back(rd_v(A_STA, MUL_STA));

        do_reset(1'b0);
        foreach (tv[i]) cyc(tv[i], "vec", i);

        // Queue fill in RESET, drop saturation, pop+push when full, drain.
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) cyc(wr_v(A_CMD, 16'h8001, 2'b11), "fill", i);
        cyc(rd_v(A_FST, 16'h2204), "fst_full", 0);
        for (int i = 0; i < 14; i++) cyc(wr_v(A_CMD, 16'h8001, 2'b11), "over", i);
        cyc(rd_v(A_FST, 16'hF204), "fst_sat", 0);
        g_s = 1'b1;
        cyc(idle_v(), "go", 0);
        cyc(wr_v(A_CMD, 16'h8001, 2'b11), "pushpop", 0);
        begin
            logic [15:0] dexp [5];
            dexp[0] = 16'hF204; dexp[1] = 16'hF003; dexp[2] = 16'hF002;
            dexp[3] = 16'hF001; dexp[4] = 16'hF100;
            for (int k = 0; k < 5; k++) cyc(rd_v(A_FST, dexp[k]), "drain", k);
        end

        // Export lockout: violating command drives EXP, int2, read masking.
        do_reset(1'b1);
        g_s = 1'b1;
        cyc(rd_v(A_VER, 16'h8320 | MINOR), "exp_ver", 0);
        cyc(wr_v(A_CON, 16'h0200, 2'b10), "exp_con", 0);
        cyc(wr_v(A_LFT, 16'h0055, 2'b11), "exp_lft", 0);
        cyc(rd_v(A_LFT, 16'h0055), "exp_lft_rd", 0);
        cyc(wr_v(A_CMD, 16'h8006, 2'b11), "exp_push", 0);
        cyc(rd_v(A_LFT, 16'h0000), "exp_mask_next", 0);
        cyc(rdi_v(A_STA, 16'h0208, 2'b10), "exp_sta", 0);
        cyc(rd_v(A_LFT, 16'h0000), "exp_lft0", 0);
        cyc(rd_v(A_FST, 16'h0000), "exp_fst0", 0);
        cyc(wr_v(A_CMD, 16'h8001, 2'b11), "exp_ign", 0);
        cyc(wr_v(A_STA, 16'h0200, 2'b10), "exp_clr", 0);
        cyc(rdi_v(A_STA, 16'h0008, 2'b00), "exp_sta2", 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
